// File: rtl/gdet_pkg.sv
// Shared types, widths and helpers for the goertzel_det single-bin tone detector.
package gdet_pkg;

    localparam int unsigned SIG_WIDTH     = 16;
    localparam int unsigned COEF_WIDTH    = 18;
    localparam int unsigned COEF_FRAC     = 16;
    localparam int unsigned ACC_WIDTH     = 32;
    localparam int unsigned N_WIDTH       = 10;
    localparam int unsigned PWR_WIDTH     = 2 * ACC_WIDTH;
    localparam int unsigned MIN_BLOCK_LEN = 2;

    // Full coef*state product, and the same product after dropping the fraction bits.
    localparam int unsigned PROD_WIDTH = COEF_WIDTH + ACC_WIDTH;
    localparam int unsigned CM_WIDTH   = PROD_WIDTH - COEF_FRAC;

    typedef enum logic {IDLE, RUN} gdet_state_e;

    // (coef * s) >>> COEF_FRAC at full precision; the shift floors toward -inf.
    function automatic logic signed [CM_WIDTH-1:0] coef_mul(
        input logic signed [COEF_WIDTH-1:0] coef,
        input logic signed [ACC_WIDTH-1:0]  s
    );
        return CM_WIDTH'((PROD_WIDTH'(coef) * PROD_WIDTH'(s)) >>> COEF_FRAC);
    endfunction

endpackage

// File: rtl/goertzel_det_if.sv
// Sample/control/result bundle of goertzel_det; master drives samples and start, slave is the detector.
interface goertzel_det_if import gdet_pkg::*; ();

    logic signed [SIG_WIDTH-1:0]  i_gdet_sample;
    logic                         i_gdet_sample_en;
    logic signed [COEF_WIDTH-1:0] i_gdet_coef;
    logic [N_WIDTH-1:0]           i_gdet_block_len;
    logic                         i_gdet_start;
    logic                         o_gdet_busy;
    logic                         o_gdet_valid;
    logic [PWR_WIDTH-1:0]         o_gdet_power;

    modport master (
        output i_gdet_sample, i_gdet_sample_en, i_gdet_coef, i_gdet_block_len, i_gdet_start,
        input  o_gdet_busy, o_gdet_valid, o_gdet_power
    );

    modport slave (
        input  i_gdet_sample, i_gdet_sample_en, i_gdet_coef, i_gdet_block_len, i_gdet_start,
        output o_gdet_busy, o_gdet_valid, o_gdet_power
    );

endinterface

// File: rtl/goertzel_power.sv
// Three-stage power pipeline: P = s1^2 + s2^2 - ((coef*s1)>>>16)*s2, clamped at 0.
module goertzel_power import gdet_pkg::*; (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         snap_valid,
    input  logic signed [COEF_WIDTH-1:0] snap_coef,
    input  logic signed [ACC_WIDTH-1:0]  snap_s1,
    input  logic signed [ACC_WIDTH-1:0]  snap_s2,
    output logic                         power_valid,
    output logic [PWR_WIDTH-1:0]         power
);

    localparam int unsigned Q_WIDTH   = CM_WIDTH + ACC_WIDTH;
    localparam int unsigned SUM_WIDTH = Q_WIDTH + 2;

    logic                         a_vld_q;
    logic signed [PWR_WIDTH-1:0]  a_p1_q;
    logic signed [CM_WIDTH-1:0]   a_m_q;
    logic signed [ACC_WIDTH-1:0]  a_s2_q;

    logic                         b_vld_q;
    logic signed [PWR_WIDTH-1:0]  b_p1_q;
    logic signed [PWR_WIDTH-1:0]  b_p2_q;
    logic signed [Q_WIDTH-1:0]    b_q_q;

    logic signed [SUM_WIDTH-1:0]  sum;
    logic [PWR_WIDTH-1:0]         power_d;
    logic                         power_valid_q;
    logic [PWR_WIDTH-1:0]         power_q;

    always_comb begin
        sum = SUM_WIDTH'(b_p1_q) + SUM_WIDTH'(b_p2_q) - SUM_WIDTH'(b_q_q);
        power_d = '0;
        // Only truncation in m can push P below zero; that is reported as no power.
        if (sum >= 0) begin
            power_d = PWR_WIDTH'(sum);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_vld_q       <= 1'b0;
            a_p1_q        <= '0;
            a_m_q         <= '0;
            a_s2_q        <= '0;
            b_vld_q       <= 1'b0;
            b_p1_q        <= '0;
            b_p2_q        <= '0;
            b_q_q         <= '0;
            power_valid_q <= 1'b0;
            power_q       <= '0;
        end else begin
            a_vld_q       <= snap_valid;
            a_p1_q        <= PWR_WIDTH'(snap_s1) * PWR_WIDTH'(snap_s1);
            a_m_q         <= coef_mul(snap_coef, snap_s1);
            a_s2_q        <= snap_s2;
            b_vld_q       <= a_vld_q;
            b_p1_q        <= a_p1_q;
            b_p2_q        <= PWR_WIDTH'(a_s2_q) * PWR_WIDTH'(a_s2_q);
            b_q_q         <= Q_WIDTH'(a_m_q) * Q_WIDTH'(a_s2_q);
            power_valid_q <= b_vld_q;
            if (b_vld_q) begin
                power_q <= power_d;
            end
        end
    end

    assign power_valid = power_valid_q;
    assign power       = power_q;

endmodule

// File: rtl/goertzel_det.sv
// Goertzel single-bin detector: FSM, sample counter, recursion and snapshot feeding goertzel_power.
// Define GDET_CONT_EN for continuous mode (back-to-back blocks while start is held high).
module goertzel_det import gdet_pkg::*; (
    input  logic           clk,
    input  logic           rst,
    goertzel_det_if.slave  gdet
);

    gdet_state_e                  state_q, state_d;
    logic signed [COEF_WIDTH-1:0] coef_q, coef_d;
    logic [N_WIDTH-1:0]           len_q, len_d;
    logic [N_WIDTH-1:0]           cnt_q, cnt_d;
    logic signed [ACC_WIDTH-1:0]  s1_q, s1_d;
    logic signed [ACC_WIDTH-1:0]  s2_q, s2_d;
    logic signed [COEF_WIDTH-1:0] snap_coef_q, snap_coef_d;
    logic signed [ACC_WIDTH-1:0]  snap_s1_q, snap_s1_d;
    logic signed [ACC_WIDTH-1:0]  snap_s2_q, snap_s2_d;
    logic                         snap_vld_q, snap_vld_d;

    logic signed [ACC_WIDTH-1:0]  s0;
    logic                         start_ok;
    logic                         pwr_valid;
    logic [PWR_WIDTH-1:0]         pwr;

    assign start_ok = gdet.i_gdet_start &&
                      (gdet.i_gdet_block_len >= N_WIDTH'(MIN_BLOCK_LEN));

    // Wraps modulo 2^ACC_WIDTH, so only the low bits of the feedback term matter.
    assign s0 = ACC_WIDTH'(gdet.i_gdet_sample) + ACC_WIDTH'(coef_mul(coef_q, s1_q)) - s2_q;

    always_comb begin
        state_d     = state_q;
        coef_d      = coef_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        snap_coef_d = snap_coef_q;
        snap_s1_d   = snap_s1_q;
        snap_s2_d   = snap_s2_q;
        snap_vld_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = RUN;
                    coef_d  = gdet.i_gdet_coef;
                    len_d   = gdet.i_gdet_block_len;
                    cnt_d   = '0;
                    s1_d    = '0;
                    s2_d    = '0;
                end
            end
            RUN: begin
                if (gdet.i_gdet_sample_en) begin
                    s2_d  = s1_q;
                    s1_d  = s0;
                    cnt_d = cnt_q + N_WIDTH'(1);
                    if (cnt_q == len_q - N_WIDTH'(1)) begin
                        snap_coef_d = coef_q;
                        snap_s1_d   = s0;
                        snap_s2_d   = s1_q;
                        snap_vld_d  = 1'b1;
                        state_d     = IDLE;
`ifdef GDET_CONT_EN
                        if (start_ok) begin
                            state_d = RUN;
                            coef_d  = gdet.i_gdet_coef;
                            len_d   = gdet.i_gdet_block_len;
                            cnt_d   = '0;
                            s1_d    = '0;
                            s2_d    = '0;
                        end
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            coef_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            snap_coef_q <= '0;
            snap_s1_q   <= '0;
            snap_s2_q   <= '0;
            snap_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            coef_q      <= coef_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            snap_coef_q <= snap_coef_d;
            snap_s1_q   <= snap_s1_d;
            snap_s2_q   <= snap_s2_d;
            snap_vld_q  <= snap_vld_d;
        end
    end

    goertzel_power u_power (
        .clk         (clk),
        .rst         (rst),
        .snap_valid  (snap_vld_q),
        .snap_coef   (snap_coef_q),
        .snap_s1     (snap_s1_q),
        .snap_s2     (snap_s2_q),
        .power_valid (pwr_valid),
        .power       (pwr)
    );

    assign gdet.o_gdet_busy  = (state_q == RUN);
    assign gdet.o_gdet_valid = pwr_valid;
    assign gdet.o_gdet_power = pwr;

endmodule

// File: tb/tb_goertzel_det.sv
// Directed bench for goertzel_det: per-cycle comparison against a block-level model plus literal checks.
module tb_goertzel_det;
    import gdet_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    goertzel_det_if gif ();

    goertzel_det dut (
        .clk  (clk),
        .rst  (rst),
        .gdet (gif)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int ncyc   = 0;

    always @(posedge clk) ncyc <= ncyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, ncyc);
        end
    endtask

    // Block power from the Goertzel definition, in wide plain integers.
    function automatic logic [63:0] gz_power(input int xs[$], input int coef);
        longint s1 = 0;
        longint s2 = 0;
        longint s0;
        longint m;
        logic signed [127:0] a, b, c, p;
        foreach (xs[i]) begin
            s0 = longint'(xs[i]) + ((longint'(coef) * s1) >>> 16) - s2;
            s0 = longint'(int'(s0));
            s2 = s1;
            s1 = s0;
        end
        m = (longint'(coef) * s1) >>> 16;
        a = s1;
        b = s2;
        c = m;
        p = a * a + b * b - c * b;
        if (p < 0) return 64'd0;
        return p[63:0];
    endfunction

    typedef struct {
        int          due;
        logic [63:0] pwr;
    } pend_t;

    bit          model_ready = 1'b0;
    bit          m_run = 1'b0;
    int          m_coef, m_len;
    int          mcyc = 0;
    int          samples[$];
    pend_t       pend[$];
    logic        exp_busy, exp_valid;
    logic [63:0] exp_power;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_run = 1'b0;
                samples.delete();
                pend.delete();
                exp_busy  = 1'b0;
                exp_valid = 1'b0;
                exp_power = '0;
            end else begin
                exp_valid = 1'b0;
                if (pend.size() > 0 && pend[0].due == mcyc) begin
                    exp_valid = 1'b1;
                    exp_power = pend[0].pwr;
                    void'(pend.pop_front());
                end
                if (!m_run) begin
                    if (gif.i_gdet_start && gif.i_gdet_block_len >= 2) begin
                        m_run  = 1'b1;
                        m_coef = int'(gif.i_gdet_coef);
                        m_len  = int'(gif.i_gdet_block_len);
                        samples.delete();
                    end
                end else if (gif.i_gdet_sample_en) begin
                    samples.push_back(int'(gif.i_gdet_sample));
                    if (samples.size() == m_len) begin
                        // Strobe seen at edge P: result visible after edge P+3 (4 cycles later).
                        pend.push_back('{mcyc + 3, gz_power(samples, m_coef)});
                        m_run = 1'b0;
`ifdef GDET_CONT_EN
                        if (gif.i_gdet_start && gif.i_gdet_block_len >= 2) begin
                            m_run  = 1'b1;
                            m_coef = int'(gif.i_gdet_coef);
                            m_len  = int'(gif.i_gdet_block_len);
                            samples.delete();
                        end
`endif
                    end
                end
                exp_busy = m_run;
            end
            mcyc++;
            model_ready = 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_ready) begin
                check("busy", 64'(gif.o_gdet_busy), 64'(exp_busy));
                check("valid", 64'(gif.o_gdet_valid), 64'(exp_valid));
                check("power", gif.o_gdet_power, exp_power);
            end
        end
    end

    logic [63:0] cap_pwr[$];
    int          cap_cyc[$];

    initial begin
        forever begin
            @(negedge clk);
            if (gif.o_gdet_valid === 1'b1) begin
                cap_pwr.push_back(gif.o_gdet_power);
                cap_cyc.push_back(ncyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_caps();
        cap_pwr.delete();
        cap_cyc.delete();
    endtask

    task automatic do_start(input int coef, input int len, input bit en_too, input int xj);
        gif.i_gdet_start     = 1'b1;
        gif.i_gdet_coef      = COEF_WIDTH'(coef);
        gif.i_gdet_block_len = N_WIDTH'(len);
        gif.i_gdet_sample_en = en_too;
        gif.i_gdet_sample    = SIG_WIDTH'(xj);
        tick();
        gif.i_gdet_start     = 1'b0;
        gif.i_gdet_sample_en = 1'b0;
    endtask

    task automatic feed(input int xs[$], input int gap, output int last_cyc);
        last_cyc = 0;
        foreach (xs[i]) begin
            gif.i_gdet_sample    = SIG_WIDTH'(xs[i]);
            gif.i_gdet_sample_en = 1'b1;
            last_cyc = ncyc;
            tick();
            gif.i_gdet_sample_en = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic expect_one(input string name, input logic [63:0] req);
        check({name, "_count"}, 64'(cap_pwr.size()), 64'd1);
        if (cap_pwr.size() > 0) check(name, cap_pwr[0], req);
    endtask

    int v_on[$]  = '{1000, 0, -1000, 0};
    int v_dc[$]  = '{1000, 1000, 1000, 1000};
    int v_one[$] = '{1, 0, 0};
    int v_mix[$] = '{-32768, 32767, 1234, -20000, 777};
    int last;

    initial begin
        gif.i_gdet_sample    = '0;
        gif.i_gdet_sample_en = 1'b0;
        gif.i_gdet_coef      = '0;
        gif.i_gdet_block_len = '0;
        gif.i_gdet_start     = 1'b0;

        // Model pins.
        check("pin_onbin", gz_power(v_on, 0), 64'd4000000);
        check("pin_dc", gz_power(v_dc, 0), 64'd0);
        check("pin_unity", gz_power(v_one, 65536), 64'd1);

        // Reset with random inputs.
        repeat (6) begin
            gif.i_gdet_sample    = SIG_WIDTH'($urandom);
            gif.i_gdet_sample_en = 1'($urandom);
            gif.i_gdet_coef      = COEF_WIDTH'($urandom);
            gif.i_gdet_block_len = N_WIDTH'($urandom);
            gif.i_gdet_start     = 1'($urandom);
            tick();
        end
        check("rst_busy", 64'(gif.o_gdet_busy), 64'd0);
        check("rst_valid", 64'(gif.o_gdet_valid), 64'd0);
        check("rst_power", gif.o_gdet_power, 64'd0);
        gif.i_gdet_start     = 1'b0;
        gif.i_gdet_sample_en = 1'b0;
        rst = 1'b0;
        tick();
        clear_caps();
        feed(v_dc, 0, last);
        repeat (8) tick();
        check("nostart_valid_count", 64'(cap_pwr.size()), 64'd0);
        check("nostart_busy", 64'(gif.o_gdet_busy), 64'd0);

        // On-bin tone with gaps between strobes.
        clear_caps();
        do_start(0, 4, 1'b0, 0);
        feed(v_on, 2, last);
        repeat (8) tick();
        expect_one("onbin", 64'd4000000);

        // Off-bin DC, strobes back to back: latency and pulse width.
        clear_caps();
        do_start(0, 4, 1'b0, 0);
        feed(v_dc, 0, last);
        check("latency_busy_low", 64'(gif.o_gdet_busy), 64'd0);
        repeat (8) tick();
        expect_one("dc", 64'd0);
        if (cap_cyc.size() > 0) check("latency", 64'(cap_cyc[0] - last), 64'd4);

        // Start with len = 1 is ignored.
        clear_caps();
        do_start(0, 1, 1'b0, 0);
        check("len1_busy", 64'(gif.o_gdet_busy), 64'd0);
        feed(v_on, 0, last);
        repeat (8) tick();
        check("len1_valid_count", 64'(cap_pwr.size()), 64'd0);

        // Start during RUN is ignored.
        clear_caps();
        do_start(0, 4, 1'b0, 0);
        feed(v_on[0:1], 0, last);
        do_start(12345, 3, 1'b0, 0);
        feed(v_on[2:3], 0, last);
        repeat (8) tick();
        expect_one("start_in_run", 64'd4000000);

        // Strobe coinciding with the accepted start is not accumulated.
        clear_caps();
        do_start(0, 4, 1'b1, 5000);
        feed(v_on, 0, last);
        repeat (8) tick();
        expect_one("start_overlap", 64'd4000000);

        // Unity coefficient and a wide mixed vector exercise the multiply path.
        clear_caps();
        do_start(65536, 3, 1'b0, 0);
        feed(v_one, 1, last);
        repeat (8) tick();
        expect_one("unity", 64'd1);
        do_start(-70001, 5, 1'b0, 0);
        feed(v_mix, 0, last);
        repeat (8) tick();

        // Reset mid-block, then mid-pipeline: nothing is reported.
        clear_caps();
        do_start(0, 4, 1'b0, 0);
        feed(v_on[0:1], 0, last);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        do_start(0, 4, 1'b0, 0);
        feed(v_on, 0, last);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (8) tick();
        check("rst_mid_valid_count", 64'(cap_pwr.size()), 64'd0);
        check("rst_mid_busy", 64'(gif.o_gdet_busy), 64'd0);
        do_start(0, 4, 1'b0, 0);
        feed(v_on, 0, last);
        repeat (8) tick();
        expect_one("after_rst", 64'd4000000);

`ifdef GDET_CONT_EN
        // Continuous mode: two back-to-back blocks with start held.
        clear_caps();
        gif.i_gdet_start     = 1'b1;
        gif.i_gdet_coef      = '0;
        gif.i_gdet_block_len = N_WIDTH'(4);
        tick();
        for (int i = 0; i < 8; i++) begin
            gif.i_gdet_sample    = SIG_WIDTH'((i < 4) ? v_on[i] : v_dc[i - 4]);
            gif.i_gdet_sample_en = 1'b1;
            if (i == 7) gif.i_gdet_start = 1'b0;
            tick();
        end
        gif.i_gdet_sample_en = 1'b0;
        repeat (8) tick();
        check("cont_count", 64'(cap_pwr.size()), 64'd2);
        if (cap_pwr.size() > 1) begin
            check("cont_first", cap_pwr[0], 64'd4000000);
            check("cont_second", cap_pwr[1], 64'd0);
        end
`endif

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
